// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter with a small TX FIFO and 8N1 serializer on the core's load/store bus.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        W_en,
  input  logic        R_en,
  input  logic [31:0] addr,
  input  logic [2:0]  RW_type,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        tx,
  output logic        irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_d;
  logic [15:0]        baud_div, bit_div, div_d, baud_cnt, cnt_d;
  logic [2:0]         bit_idx, idx_d;
  logic [7:0]         shift, shift_d;
  logic               par_bit, par_d, tx_d, bit_end;
  logic               ovf, full, empty, busy, push, pop;
  logic               sel, wr_txdata, wr_status, wr_baud;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        reg_val;
  logic               unused_din;

  assign unused_din = ^din[31:16];

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
  assign wr_txdata = W_en && sel && (addr[3:2] == 2'b00);
  assign wr_status = W_en && sel && (addr[3:2] == 2'b01);
  assign wr_baud   = W_en && sel && (addr[3:2] == 2'b10);

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  // Push is judged on pre-pop occupancy, so a store to a full FIFO is dropped even if a pop happens.
  assign push    = wr_txdata && !full;
  assign pop     = (state == IDLE) && !empty;
  assign bit_end = (baud_cnt == bit_div);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= din[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (wr_txdata && full) ovf <= 1'b1;
      else if (wr_status)    ovf <= 1'b0;
      if (wr_baud) begin
        if (RW_type[1:0] == 2'b00) baud_div[7:0] <= din[7:0];
        else                       baud_div      <= din[15:0];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= cnt_d;
      bit_idx  <= idx_d;
      tx       <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift   <= shift_d;
    bit_div <= div_d;
    par_bit <= par_d;
  end

  // FSM next state
  always_comb begin
    state_d = state;
    cnt_d   = baud_cnt;
    idx_d   = bit_idx;
    shift_d = shift;
    div_d   = bit_div;
    par_d   = par_bit;
    if (state == IDLE) begin
      if (!empty) begin
        state_d = START;
        cnt_d   = '0;
        idx_d   = '0;
        shift_d = fifo_mem[rd_ptr];
        par_d   = ^fifo_mem[rd_ptr];
        div_d   = baud_div;
      end
    end else if (bit_end) begin
      cnt_d = '0;
      case (state)
        START: state_d = DATA;
        DATA: begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d   = bit_idx + 3'd1;
            shift_d = {1'b0, shift[7:1]};
          end
        end
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end else begin
      cnt_d = baud_cnt + 16'd1;
    end
  end

  // FSM output: tx is registered from the level of the upcoming state
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    reg_val = '0;
    case (addr[3:2])
      2'b01:   reg_val = {27'b0, ovf, busy, empty, full, 1'b0};
      2'b10:   reg_val = {16'b0, baud_div};
      default: reg_val = '0;
    endcase
  end

  always_comb begin
    dout = '0;
    if (rst_n && R_en && sel) begin
      case (RW_type)
        3'b000:  dout = {{24{reg_val[7]}}, reg_val[7:0]};
        3'b100:  dout = {24'b0, reg_val[7:0]};
        3'b001:  dout = {{16{reg_val[15]}}, reg_val[15:0]};
        3'b101:  dout = {16'b0, reg_val[15:0]};
        default: dout = reg_val;
      endcase
    end
  end

  assign irq = !rst_n || ((state == IDLE) && empty);

endmodule
